// File: rtl/rdma_stream_demux_pkg.sv
// =============================================================================
// Module   : cnn_dma_pkg
// Purpose  : Shared state encodings, bank count and address-width helper for
//            the RDMA stream demultiplexer.
// Revision : 1.0
// =============================================================================
`default_nettype none

package cnn_dma_pkg;

  localparam int NUM_INFMAP_BANK = 2;

  typedef logic [1:0] dma_state_t;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PARAM  = 2'd1;
  localparam logic [1:0] S_INFMAP = 2'd2;

  // A one-word buffer still needs a one-bit address.
  function automatic int addr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rdma_stream_demux_if.sv
// =============================================================================
// Module   : rdma_stream_demux_if
// Purpose  : RDMA stream port: data/write strobe, backpressure and load tags.
// Revision : 1.0
// =============================================================================
`default_nettype none

interface rdma_stream_demux_if #(
  parameter int DATA_W = 32
) ();

  logic [DATA_W-1:0] din;
  logic              write;
  logic              full_n;
  logic              rd_param;
  logic              rd_infmap;

  modport master (output din, write, rd_param, rd_infmap, input full_n);
  modport slave  (input din, write, rd_param, rd_infmap, output full_n);

endinterface

`default_nettype wire

// File: rtl/rdma_stream_demux_infmap_bank_ctrl.sv
// =============================================================================
// Module   : infmap_bank_ctrl
// Purpose  : Ping-pong bank pointer and per-bank ownership handed to the core.
// Revision : 1.0
// =============================================================================
`default_nettype none

module infmap_bank_ctrl
  import cnn_dma_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_done,
  input  logic [NUM_INFMAP_BANK-1:0] bank_release,
  output logic                       ptr,
  output logic [NUM_INFMAP_BANK-1:0] bank_valid
);

  logic [NUM_INFMAP_BANK-1:0] set_mask;

  always_comb begin
    set_mask      = '0;
    set_mask[ptr] = load_done;
  end

  // A set overrides a simultaneous release of the same bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= 1'b0;
      bank_valid <= '0;
    end else begin
      bank_valid <= (bank_valid & ~bank_release) | set_mask;
      if (load_done) ptr <= ~ptr;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rdma_stream_demux.sv
// =============================================================================
// Module   : rdma_stream_demux
// Purpose  : Routes RDMA stream words to the parameter buffer or ping-pong
//            infmap banks with sequential addressing and backpressure.
// Revision : 1.0
// =============================================================================
`default_nettype none

module rdma_stream_demux
  import cnn_dma_pkg::*;
#(
  parameter int C_DATA_W      = 32,
  parameter int NUM_RD_PARAM  = 1,
  parameter int NUM_RD_INFMAP = 1,
  parameter int PARAM_AW      = addr_width(NUM_RD_PARAM),
  parameter int INFMAP_AW     = addr_width(NUM_RD_INFMAP)
) (
  input  logic                       ap_clk,
  input  logic                       areset,
  rdma_stream_demux_if.slave         strm,
  output logic                       o_param_we,
  output logic [PARAM_AW-1:0]        o_param_addr,
  output logic [C_DATA_W-1:0]        o_param_wdata,
  output logic                       o_param_done,
  output logic                       o_infmap_we,
  output logic                       o_infmap_bank,
  output logic [INFMAP_AW-1:0]       o_infmap_addr,
  output logic [C_DATA_W-1:0]        o_infmap_wdata,
  output logic [NUM_INFMAP_BANK-1:0] o_bank_valid,
  input  logic [NUM_INFMAP_BANK-1:0] i_bank_release,
  output logic                       o_ovf_err,
  output logic                       o_idle
);

  localparam logic [PARAM_AW-1:0]  PARAM_LAST  = PARAM_AW'(NUM_RD_PARAM - 1);
  localparam logic [INFMAP_AW-1:0] INFMAP_LAST = INFMAP_AW'(NUM_RD_INFMAP - 1);

  dma_state_t           state, state_nxt;
  logic                 full_n;
  logic [PARAM_AW-1:0]  param_cnt;
  logic [INFMAP_AW-1:0] infmap_cnt;
  logic                 ptr;
  logic                 accept, param_acc, infmap_acc, param_last, infmap_last;

  assign accept      = strm.write & full_n;
  assign param_acc   = accept && (state == S_PARAM);
  assign infmap_acc  = accept && (state == S_INFMAP);
  assign param_last  = param_acc && (param_cnt == PARAM_LAST);
  assign infmap_last = infmap_acc && (infmap_cnt == INFMAP_LAST);
  assign strm.full_n = full_n;
  assign o_idle      = (state == S_IDLE);

  // Tags are sampled only in idle; a tag dropping mid-load is ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (strm.rd_param)                               state_nxt = S_PARAM;
        else if (strm.rd_infmap && !o_bank_valid[ptr])   state_nxt = S_INFMAP;
      end
      S_PARAM:  if (param_last)  state_nxt = S_IDLE;
      S_INFMAP: if (infmap_last) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state          <= S_IDLE;
      full_n         <= 1'b0;
      param_cnt      <= '0;
      infmap_cnt     <= '0;
      o_param_we     <= 1'b0;
      o_param_addr   <= '0;
      o_param_wdata  <= '0;
      o_param_done   <= 1'b0;
      o_infmap_we    <= 1'b0;
      o_infmap_bank  <= 1'b0;
      o_infmap_addr  <= '0;
      o_infmap_wdata <= '0;
      o_ovf_err      <= 1'b0;
    end else begin
      state          <= state_nxt;
      full_n         <= (state_nxt == S_PARAM) || (state_nxt == S_INFMAP);
      o_param_we     <= param_acc;
      o_param_addr   <= param_cnt;
      o_param_wdata  <= strm.din;
      o_param_done   <= param_last;
      o_infmap_we    <= infmap_acc;
      o_infmap_bank  <= ptr;
      o_infmap_addr  <= infmap_cnt;
      o_infmap_wdata <= strm.din;
      if (strm.write && !full_n) o_ovf_err <= 1'b1;
      if (param_acc)  param_cnt  <= param_last  ? '0 : param_cnt + 1'b1;
      if (infmap_acc) infmap_cnt <= infmap_last ? '0 : infmap_cnt + 1'b1;
    end
  end

  infmap_bank_ctrl u_bank_ctrl (
    .clk          (ap_clk),
    .rst          (areset),
    .load_done    (infmap_last),
    .bank_release (i_bank_release),
    .ptr          (ptr),
    .bank_valid   (o_bank_valid)
  );

endmodule

`default_nettype wire

// File: tb/tb_rdma_stream_demux.sv
// =============================================================================
// Module   : tb_rdma_stream_demux
// Purpose  : Directed + random stimulus against a word-count reference model.
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_rdma_stream_demux;

  localparam int NP = 4;
  localparam int NI = 3;

  logic        ap_clk = 1'b0;
  logic        areset;
  logic        param_we, param_done, infmap_we, infmap_bank, ovf_err, idle;
  logic [1:0]  param_addr, infmap_addr, bank_valid, bank_release;
  logic [31:0] param_wdata, infmap_wdata;

  int total = 0;
  int bad   = 0;

  rdma_stream_demux_if #(.DATA_W(32)) strm ();

  rdma_stream_demux #(
    .C_DATA_W(32), .NUM_RD_PARAM(NP), .NUM_RD_INFMAP(NI)
  ) dut (
    .ap_clk         (ap_clk),
    .areset         (areset),
    .strm           (strm),
    .o_param_we     (param_we),
    .o_param_addr   (param_addr),
    .o_param_wdata  (param_wdata),
    .o_param_done   (param_done),
    .o_infmap_we    (infmap_we),
    .o_infmap_bank  (infmap_bank),
    .o_infmap_addr  (infmap_addr),
    .o_infmap_wdata (infmap_wdata),
    .o_bank_valid   (bank_valid),
    .i_bank_release (bank_release),
    .o_ovf_err      (ovf_err),
    .o_idle         (idle)
  );

  always #5 ap_clk = ~ap_clk;

  // Reference model: 0 = idle, 1 = loading params, 2 = loading infmap.
  int          mode = 0, pcnt = 0, icnt = 0;
  bit          owned [2];
  bit          cur_bank = 0, m_ovf = 0, m_valid = 0;
  bit          e_pwe = 0, e_pdone = 0, e_iwe = 0, e_ibank = 0;
  int          e_paddr = 0, e_iaddr = 0;
  logic [31:0] e_pdata = '0, e_idata = '0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit wr, input logic [31:0] din,
                            input bit rp, input bit ri, input logic [1:0] rel);
    bit full;
    bit old_owned [2];
    if (rst) begin
      mode = 0; pcnt = 0; icnt = 0; cur_bank = 0; m_ovf = 0;
      owned[0] = 0; owned[1] = 0;
      e_pwe = 0; e_pdone = 0; e_iwe = 0;
      return;
    end
    full = (mode != 0);
    old_owned = owned;
    e_pwe = 0; e_pdone = 0; e_iwe = 0;
    if (wr && !full) m_ovf = 1;
    for (int b = 0; b < 2; b++) if (rel[b]) owned[b] = 0;
    if (wr && full) begin
      if (mode == 1) begin
        e_pwe = 1; e_paddr = pcnt; e_pdata = din; pcnt++;
        if (pcnt == NP) begin pcnt = 0; e_pdone = 1; mode = 0; end
      end else begin
        e_iwe = 1; e_ibank = cur_bank; e_iaddr = icnt; e_idata = din; icnt++;
        if (icnt == NI) begin
          icnt = 0; owned[cur_bank] = 1; cur_bank = ~cur_bank; mode = 0;
        end
      end
    end else if (mode == 0) begin
      if (rp) mode = 1;
      else if (ri && !old_owned[cur_bank]) mode = 2;
    end
  endtask

  // Called at a negedge: check outputs, drive inputs, advance the model, run one clock.
  task automatic step(input bit rst, input bit wr, input logic [31:0] din,
                      input bit rp, input bit ri, input logic [1:0] rel);
    if (m_valid) begin
      check_val("full_n",     {31'd0, strm.full_n}, {31'd0, mode != 0});
      check_val("idle",       {31'd0, idle},        {31'd0, mode == 0});
      check_val("bank_valid", {30'd0, bank_valid},  {30'd0, owned[1], owned[0]});
      check_val("ovf_err",    {31'd0, ovf_err},     {31'd0, m_ovf});
      check_val("param_we",   {31'd0, param_we},    {31'd0, e_pwe});
      check_val("param_done", {31'd0, param_done},  {31'd0, e_pdone});
      check_val("infmap_we",  {31'd0, infmap_we},   {31'd0, e_iwe});
      if (e_pwe) begin
        check_val("param_addr",  {30'd0, param_addr}, e_paddr);
        check_val("param_wdata", param_wdata,         e_pdata);
      end
      if (e_iwe) begin
        check_val("infmap_bank",  {31'd0, infmap_bank}, {31'd0, e_ibank});
        check_val("infmap_addr",  {30'd0, infmap_addr}, e_iaddr);
        check_val("infmap_wdata", infmap_wdata,         e_idata);
      end
    end
    areset         = rst;
    strm.write     = wr;
    strm.din       = din;
    strm.rd_param  = rp;
    strm.rd_infmap = ri;
    bank_release   = rel;
    model_step(rst, wr, din, rp, ri, rel);
    if (rst) m_valid = 1;
    @(posedge ap_clk);
    @(negedge ap_clk);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, 0, 2'b00);
  endtask

  task automatic load_infmap(input logic [31:0] base);
    step(0, 0, 32'h0, 0, 1, 2'b00);
    for (int i = 0; i < NI; i++) step(0, 1, base + 32'(i), 0, 0, 2'b00);
  endtask

  initial begin
    areset = 1'b1; strm.write = 0; strm.din = '0;
    strm.rd_param = 0; strm.rd_infmap = 0; bank_release = '0;
    @(negedge ap_clk);
    step(1, 0, 32'h0, 0, 0, 2'b00);
    step(1, 0, 32'h0, 0, 0, 2'b00);
    idle_n(1);

    // Parameter load of four back-to-back words.
    step(0, 0, 32'h0, 1, 0, 2'b00);
    for (int i = 0; i < NP; i++) step(0, 1, 32'hA0 + 32'(i), 0, 0, 2'b00);
    idle_n(2);

    // Two infmap loads fill both banks; a third request stalls.
    load_infmap(32'hB0);
    load_infmap(32'hC0);
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 0, 1, 2'b00);
    step(0, 0, 32'h0, 0, 1, 2'b01);
    step(0, 0, 32'h0, 0, 1, 2'b00);
    for (int i = 0; i < NI; i++) step(0, 1, 32'hD0 + 32'(i), 0, 0, 2'b00);
    idle_n(1);

    // Both tags high: param first, then infmap.
    step(0, 0, 32'h0, 0, 0, 2'b11);
    step(0, 0, 32'h0, 1, 1, 2'b00);
    for (int i = 0; i < NP; i++) step(0, 1, 32'hE0 + 32'(i), 0, 1, 2'b00);
    step(0, 0, 32'h0, 0, 1, 2'b00);
    for (int i = 0; i < NI; i++) step(0, 1, 32'hF0 + 32'(i), 0, 0, 2'b00);
    idle_n(1);

    // Gapped strobes, the first while full_n is low.
    step(0, 1, 32'h11, 0, 1, 2'b11);
    step(0, 0, 32'h12, 0, 0, 2'b00);
    step(0, 1, 32'h13, 0, 0, 2'b00);
    step(0, 0, 32'h14, 0, 0, 2'b00);
    step(0, 1, 32'h15, 0, 0, 2'b00);
    step(0, 1, 32'h16, 0, 0, 2'b00);
    idle_n(1);

    // Reset in the middle of an infmap load.
    step(0, 0, 32'h0, 0, 1, 2'b11);
    step(0, 1, 32'h21, 0, 0, 2'b00);
    step(0, 1, 32'h22, 0, 0, 2'b00);
    step(1, 0, 32'h0, 0, 0, 2'b00);
    idle_n(1);
    load_infmap(32'h30);
    idle_n(1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 9) < 7),
           $urandom(),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) < 3),
           {($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0)});
    end
    idle_n(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
